mips_multicycle_datapath: RTL and testbench

- Multicycle MIPS datapath. It sits directly downstream of the control unit and consumes every control signal it drives.
- Holds PC, IR, MDR, A, B, ALUOut and the 32x32 register file, plus the ALU and all source muxes.
- Feeds opcode/funct back to the control unit.
- Talks to a unified instruction/data memory with combinational read.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/mips_multicycle_datapath_reg_file.sv | 33 +++
 rtl/mips_multicycle_datapath.sv | 124 ++++++++++++
 tb/tb_mips_multicycle_datapath.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its control unit.
// Control-input codes, opcodes and register-file geometry live here.
package mips_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU     = 2'b00,
        PC_SRC_ALU_OUT = 2'b01,
        PC_SRC_JUMP    = 2'b10,
        PC_SRC_HOLD    = 2'b11
    } pc_src_t;

    typedef enum logic [5:0] {
        R_TYPE = 6'h00,
        J      = 6'h02,
        BEQ    = 6'h04,
        ADDI   = 6'h08,
        LW     = 6'h23,
        SW     = 6'h2B
    } opcode_t;

    function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_multicycle_datapath_reg_file.sv
// 32-entry register file: two asynchronous read ports, one synchronous write port.
// r0 is cleared on reset and never written, so it always reads zero.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]      wd,
    output logic [WIDTH-1:0]      rd1,
    output logic [WIDTH-1:0]      rd2
);

    logic [WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the pre-write value.
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and muxes.
// Every state update is steered purely by the control inputs of the current cycle.
module mips_multicycle_datapath
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_to_reg,
    input  logic             reg_dest,
    input  logic             i_or_d,
    input  logic             alu_src_a,
    input  logic             ir_write,
    input  logic             mem_write,
    input  logic             pc_write,
    input  logic             branch,
    input  logic             reg_write,
    input  logic [1:0]       alu_src_b,
    input  logic [1:0]       pc_src,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic             zero
);

    logic [WIDTH-1:0] pc, ir, mdr, a_reg, b_reg, alu_out;
    logic [WIDTH-1:0] rd1, rd2, src_a, src_b, alu_result, next_pc, sign_imm, jump_target;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [WIDTH-1:0] write_data;
    logic pc_en;

    mips_reg_file #(
        .WIDTH(WIDTH)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .we    (reg_write),
        .ra1   (ir[25:21]),
        .ra2   (ir[20:16]),
        .wa    (write_reg),
        .wd    (write_data),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign write_reg   = reg_dest ? ir[15:11] : ir[20:16];
    assign write_data  = mem_to_reg ? mdr : alu_out;
    assign sign_imm    = sign_extend16(ir[15:0]);
    assign jump_target = {pc[WIDTH-1:WIDTH-4], ir[25:0], 2'b00};
    assign src_a       = alu_src_a ? a_reg : pc;

    always_comb begin
        src_b = b_reg;
        case (alu_src_b)
            SRCB_REG:     src_b = b_reg;
            SRCB_FOUR:    src_b = WIDTH'(4);
            SRCB_IMM:     src_b = sign_imm;
            SRCB_IMM_SH2: src_b = {sign_imm[WIDTH-3:0], 2'b00};
            default:      src_b = b_reg;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        next_pc = pc;
        case (pc_src)
            PC_SRC_ALU:     next_pc = alu_result;
            PC_SRC_ALU_OUT: next_pc = alu_out;
            PC_SRC_JUMP:    next_pc = jump_target;
            PC_SRC_HOLD:    next_pc = pc;
            default:        next_pc = pc;
        endcase
    end

    assign pc_en = pc_write | (branch & zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en) begin
                pc <= next_pc;
            end
            if (ir_write) begin
                ir <= mem_rdata;
            end
            mdr     <= mem_rdata;
            a_reg   <= rd1;
            b_reg   <= rd2;
            alu_out <= alu_result;
        end
    end

    assign mem_addr  = i_or_d ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = mem_write;
    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed bench: a table of per-cycle control vectors walks addi, beq, j, sw, lw and reset,
// followed by a hand-written check that zero tracks the ALU with no clock edge.
module tb_mips_multicycle_datapath;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset, mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write;
    logic pc_write, branch, reg_write;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [31:0] mem_rdata, mem_addr, mem_wdata;
    logic mem_we, zero;
    logic [5:0] opcode, funct;

    always #5 clk = ~clk;

    mips_multicycle_datapath #(
        .RESET_PC(32'h0000_0000),
        .WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .mem_to_reg(mem_to_reg), .reg_dest(reg_dest),
        .i_or_d(i_or_d), .alu_src_a(alu_src_a), .ir_write(ir_write), .mem_write(mem_write),
        .pc_write(pc_write), .branch(branch), .reg_write(reg_write), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_control(alu_control), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .opcode(opcode), .funct(funct), .zero(zero)
    );

    typedef struct packed {
        logic       rst;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] pcsrc;
        logic       iord, irw, pcw, br, regw, rdst, m2r, memw;
    } ctrl_t;

    typedef struct {
        string       name;
        ctrl_t       c;
        logic [31:0] rdata;
        int          zexp;   // -1: zero not checked
        logic [31:0] addr;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] wd;
        logic        we;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic ctrl_t cf(input logic rst, input logic srca, input logic [1:0] srcb,
                                 input logic [2:0] aluc, input logic [1:0] pcsrc,
                                 input logic iord, input logic irw, input logic pcw,
                                 input logic br, input logic regw, input logic rdst,
                                 input logic m2r, input logic memw);
        return '{rst, srca, srcb, aluc, pcsrc, iord, irw, pcw, br, regw, rdst, m2r, memw};
    endfunction

    function automatic void add_vec(input string n, input ctrl_t c, input logic [31:0] rdata,
                                    input int zexp, input logic [31:0] addr, input logic [5:0] op,
                                    input logic [5:0] fn, input logic [31:0] wd, input logic we);
        vecs.push_back('{n, c, rdata, zexp, addr, op, fn, wd, we});
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input ctrl_t c, input logic [31:0] rdata);
        reset       = c.rst;
        alu_src_a   = c.srca;
        alu_src_b   = c.srcb;
        alu_control = c.aluc;
        pc_src      = c.pcsrc;
        i_or_d      = c.iord;
        ir_write    = c.irw;
        pc_write    = c.pcw;
        branch      = c.br;
        reg_write   = c.regw;
        reg_dest    = c.rdst;
        mem_to_reg  = c.m2r;
        mem_write   = c.memw;
        mem_rdata   = rdata;
    endtask

    localparam logic [1:0] H = PC_SRC_HOLD;

    initial begin
        ctrl_t idle, irw, exe, exe_d, sub_br;
        vec_t v;

        idle   = cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 0, 0, 0, 0);
        irw    = cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 1, 0, 0, 0, 0, 0, 0);
        exe    = cf(0, 1, SRCB_IMM, ALU_ADD, H, 0, 0, 0, 0, 0, 0, 0, 0);
        exe_d  = cf(0, 1, SRCB_IMM, ALU_ADD, H, 1, 0, 0, 0, 0, 0, 0, 0);
        sub_br = cf(0, 1, SRCB_REG, ALU_SUB, PC_SRC_ALU_OUT, 0, 0, 0, 1, 0, 0, 0, 0);

        add_vec("reset",        cf(1, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 0, 0, 0, 0), 0, -1, 32'h0, 6'h00, 6'h00, 32'h0, 0);
        add_vec("fetch_addi8",  cf(0, 0, SRCB_FOUR, ALU_ADD, PC_SRC_ALU, 0, 1, 1, 0, 0, 0, 0, 0), 32'h2008_0005, 0, 32'h4, 6'h08, 6'h05, 32'h0, 0);
        add_vec("decode_addi8", idle, 0, -1, 32'h4, 6'h08, 6'h05, 32'h0, 0);
        add_vec("exec_addi8",   exe_d, 0, 0, 32'h5, 6'h08, 6'h05, 32'h0, 0);
        add_vec("wb_addi8",     cf(0, 1, SRCB_IMM, ALU_ADD, H, 0, 0, 0, 0, 1, 0, 0, 0), 0, -1, 32'h4, 6'h08, 6'h05, 32'h0, 0);
        add_vec("read_r8",      idle, 0, -1, 32'h4, 6'h08, 6'h05, 32'h5, 0);
        add_vec("ir_addi9",     irw, 32'h2009_0005, -1, 32'h4, 6'h08, 6'h05, 32'h5, 0);
        add_vec("exec_addi9",   exe_d, 0, -1, 32'h5, 6'h08, 6'h05, 32'h0, 0);
        add_vec("wb_addi9",     cf(0, 1, SRCB_IMM, ALU_ADD, H, 0, 0, 0, 0, 1, 0, 0, 0), 0, -1, 32'h4, 6'h08, 6'h05, 32'h0, 0);
        add_vec("ir_beq",       irw, 32'h1109_0003, -1, 32'h4, 6'h04, 6'h03, 32'h5, 0);
        add_vec("decode_beq",   cf(0, 0, SRCB_IMM_SH2, ALU_ADD, H, 1, 0, 0, 0, 0, 0, 0, 0), 0, -1, 32'h10, 6'h04, 6'h03, 32'h5, 0);
        add_vec("beq_taken",    sub_br, 0, 1, 32'h10, 6'h04, 6'h03, 32'h5, 0);
        add_vec("mdr_six",      idle, 32'h6, -1, 32'h10, 6'h04, 6'h03, 32'h5, 0);
        add_vec("wb_r9_mdr",    cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 1, 0, 1, 0), 32'h6, -1, 32'h10, 6'h04, 6'h03, 32'h5, 0);
        add_vec("read_r9_six",  idle, 0, -1, 32'h10, 6'h04, 6'h03, 32'h6, 0);
        add_vec("beq_not_taken", sub_br, 0, 0, 32'h10, 6'h04, 6'h03, 32'h6, 0);
        add_vec("slt_5_lt_6",   cf(0, 1, SRCB_REG, ALU_SLT, H, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h1, 6'h04, 6'h03, 32'h6, 0);
        add_vec("bad_alu_op",   cf(0, 1, SRCB_REG, 3'b011, H, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1, 32'h0, 6'h04, 6'h03, 32'h6, 0);
        add_vec("mdr_big",      idle, 32'h0FFF_FFF4, -1, 32'h10, 6'h04, 6'h03, 32'h6, 0);
        add_vec("wb_r9_big",    cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 1, 0, 1, 0), 32'h0FFF_FFF4, -1, 32'h10, 6'h04, 6'h03, 32'h6, 0);
        add_vec("read_r9_big",  idle, 0, -1, 32'h10, 6'h04, 6'h03, 32'h0FFF_FFF4, 0);
        add_vec("pc_from_alu",  cf(0, 0, SRCB_REG, ALU_ADD, PC_SRC_ALU, 0, 0, 1, 0, 0, 0, 0, 0), 0, -1, 32'h1000_0004, 6'h04, 6'h03, 32'h0FFF_FFF4, 0);
        add_vec("ir_jump",      irw, 32'h0800_0040, -1, 32'h1000_0004, 6'h02, 6'h00, 32'h0FFF_FFF4, 0);
        add_vec("jump",         cf(0, 0, SRCB_REG, ALU_ADD, PC_SRC_JUMP, 0, 0, 1, 0, 0, 0, 0, 0), 0, -1, 32'h1000_0100, 6'h02, 6'h00, 32'h0, 0);
        add_vec("ir_sw",        irw, 32'hAD09_0008, -1, 32'h1000_0100, 6'h2B, 6'h08, 32'h0, 0);
        add_vec("decode_sw",    idle, 0, -1, 32'h1000_0100, 6'h2B, 6'h08, 32'h0FFF_FFF4, 0);
        add_vec("addr_sw",      exe, 0, -1, 32'h1000_0100, 6'h2B, 6'h08, 32'h0FFF_FFF4, 0);
        add_vec("store",        cf(0, 1, SRCB_IMM, ALU_ADD, H, 1, 0, 0, 0, 0, 0, 0, 1), 0, -1, 32'hD, 6'h2B, 6'h08, 32'h0FFF_FFF4, 1);
        add_vec("ir_lw",        irw, 32'h8D0A_0000, -1, 32'h1000_0100, 6'h23, 6'h00, 32'h0FFF_FFF4, 0);
        add_vec("addr_lw",      exe, 0, -1, 32'h1000_0100, 6'h23, 6'h00, 32'h0, 0);
        add_vec("mem_read",     exe_d, 32'hDEAD_BEEF, -1, 32'h5, 6'h23, 6'h00, 32'h0, 0);
        add_vec("wb_lw",        cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 1, 0, 1, 0), 0, -1, 32'h1000_0100, 6'h23, 6'h00, 32'h0, 0);
        add_vec("read_r10",     idle, 0, -1, 32'h1000_0100, 6'h23, 6'h00, 32'hDEAD_BEEF, 0);
        add_vec("mdr_r0",       idle, 32'h1234_5678, -1, 32'h1000_0100, 6'h23, 6'h00, 32'hDEAD_BEEF, 0);
        add_vec("wb_r0",        cf(0, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 1, 1, 1, 0), 32'h1234_5678, -1, 32'h1000_0100, 6'h23, 6'h00, 32'hDEAD_BEEF, 0);
        add_vec("ir_zero",      irw, 32'h0, -1, 32'h1000_0100, 6'h00, 6'h00, 32'hDEAD_BEEF, 0);
        add_vec("read_r0",      idle, 0, -1, 32'h1000_0100, 6'h00, 6'h00, 32'h0, 0);
        add_vec("ir_addi11",    irw, 32'h200B_0007, -1, 32'h1000_0100, 6'h08, 6'h07, 32'h0, 0);
        add_vec("exec_addi11",  exe, 0, -1, 32'h1000_0100, 6'h08, 6'h07, 32'h0, 0);
        add_vec("reset_mid",    cf(1, 1, SRCB_IMM, ALU_ADD, PC_SRC_ALU, 0, 1, 1, 0, 1, 0, 0, 0), 32'h8D0A_0000, -1, 32'h0, 6'h00, 6'h00, 32'h0, 0);
        add_vec("ir_addi11_b",  irw, 32'h200B_0007, -1, 32'h0, 6'h08, 6'h07, 32'h0, 0);
        add_vec("read_r11",     idle, 0, -1, 32'h0, 6'h08, 6'h07, 32'h0, 0);
        add_vec("ir_lw_b",      irw, 32'h8D0A_0000, -1, 32'h0, 6'h23, 6'h00, 32'h0, 0);
        add_vec("read_r10_clr", idle, 0, -1, 32'h0, 6'h23, 6'h00, 32'h0, 0);

        drive(cf(1, 0, SRCB_REG, ALU_ADD, H, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.c, v.rdata);
            #1;
            if (v.zexp >= 0) check({v.name, "/zero"}, 32'(zero), 32'(v.zexp));
            @(posedge clk);
            #1;
            check({v.name, "/mem_addr"},  mem_addr,      v.addr);
            check({v.name, "/opcode"},    32'(opcode),   32'(v.op));
            check({v.name, "/funct"},     32'(funct),    32'(v.fn));
            check({v.name, "/mem_wdata"}, mem_wdata,     v.wd);
            check({v.name, "/mem_we"},    32'(mem_we),   32'(v.we));
        end

        // A = B = 0 and PC = 0 here; zero must follow ALU controls without a clock edge.
        @(negedge clk);
        drive(cf(0, 1, SRCB_REG, ALU_SUB, H, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0);
        #1 check("comb/sub_0_0",  32'(zero), 32'h1);
        alu_src_b = SRCB_FOUR;
        #1 check("comb/sub_0_4",  32'(zero), 32'h0);
        alu_control = ALU_SLT;
        #1 check("comb/slt_0_4",  32'(zero), 32'h0);
        @(negedge clk);
        alu_control = ALU_AND;
        #1 check("comb/and_0_4",  32'(zero), 32'h1);
        alu_src_a = 1'b0;
        alu_control = ALU_OR;
        #1 check("comb/or_pc_4",  32'(zero), 32'h0);
        mem_write = 1'b1;
        #1 check("comb/mem_we",   32'(mem_we), 32'h1);
        mem_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
